// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue -- small FIFO between instruction fetch and decode.
//
// Holds up to DEPTH (power of two, >= 2) PC/instruction pairs. The head entry is
// always read from registered storage, so a pushed entry takes at least one
// cycle to reach decode. flush (branch/jump redirect) empties the queue and
// drops that cycle's input.
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   asynchronous, active-low reset
//   in_valid     in   fetch presents a PC/instruction pair
//   in_pc        in   PC of fetched instruction          [XLEN]
//   in_instr     in   fetched instruction word           [XLEN]
//   in_ready     out  queue has room (count != DEPTH)
//   out_valid    out  head entry available (count != 0)
//   out_pc       out  head PC, 0 while empty             [XLEN]
//   out_instr    out  head instruction, NOP while empty  [XLEN]
//   out_ready    in   decode consumes head entry
//   flush        in   discard all entries
//   count        out  number of valid entries           [$clog2(DEPTH+1)]
//   stall_cycles out  (FETCH_QUEUE_PERF_EN only) saturating count of cycles
//                     with in_valid=1 and in_ready=0    [32]
//
// Optional feature macro: FETCH_QUEUE_PERF_EN
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instr,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]                stall_cycles
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] instr_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic push, pop;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid  & in_ready  & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Stale storage is masked so an invalid slot is never visible.
    assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
    assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : NOP;

    // DEPTH is a power of two, so pointer overflow gives the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; validity comes solely from count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Flush does not clear this counter; only reset does.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (in_valid && !in_ready && (stall_cycles_q != 32'hFFFF_FFFF))
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_cycles_q <= '0;
        else        stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue -- scoreboard bench for fetch_queue.
// The driver issues directed cycles and pushes each accepted entry into a
// queue; a negedge monitor compares the DUT head entry against the queue front
// and pops it when decode consumes it.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, out_ready, flush;
    logic [31:0] in_pc, in_instr;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_instr;
    logic [2:0]  count;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] stall_cycles;
`endif

    fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [63:0] exp_q[$];   // {pc, instr}
    int          mcount = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h5A00_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One driven cycle: inputs applied now, model updated after the edge.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        logic mpush, mpop;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr_of(pc);
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        mpush = v && (mcount != DEPTH) && !fl;
        mpop  = (mcount != 0) && ordy && !fl;
        if (fl) begin
            mcount = 0;
            exp_q.delete();
        end else begin
            if (mpush) exp_q.push_back({pc, instr_of(pc)});
            mcount = mcount + int'(mpush) - int'(mpop);
        end
        #1;
    endtask

    // Monitor: state checks every cycle, head compare and pop on consumption.
    always @(negedge clk) begin
        if (reset) begin
            chk("count", 32'(count), 32'(mcount));
            chk("in_ready", 32'(in_ready), 32'(mcount != DEPTH));
            chk("out_valid", 32'(out_valid), 32'(mcount != 0));
            if (!out_valid) begin
                chk("empty_pc", out_pc, 32'h0);
                chk("empty_instr", out_instr, NOP);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'h0);
            end else begin
                chk("head_pc", out_pc, exp_q[0][63:32]);
                chk("head_instr", out_instr, exp_q[0][31:0]);
                if (out_ready && !flush) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        out_ready = 1'b0; flush = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, NOP);
`ifdef FETCH_QUEUE_PERF_EN
        chk("rst_stall", stall_cycles, 32'h0);
`endif
        #11 reset = 1'b1;

        // Fill to full with decode stalled.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'h0);
        chk("full_out_pc", out_pc, 32'h0);
        // Push attempts while full are ignored.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h10, 1'b0, 1'b0);
        chk("full_hold_count", 32'(count), 32'd4);
`ifdef FETCH_QUEUE_PERF_EN
        chk("stall_cycles", stall_cycles, 32'd3);
`endif
        // Drain in order.
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drained_valid", 32'(out_valid), 32'h0);
        chk("drained_instr", out_instr, NOP);

        // Steady streaming at count=2 across pointer wrap.
        cyc(1'b1, 32'h20, 1'b0, 1'b0);
        cyc(1'b1, 32'h24, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'h28 + 32'(i * 4), 1'b1, 1'b0);
        chk("stream_count", 32'(count), 32'd2);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush wins over simultaneous push and pop.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h80 + 32'(i * 4), 1'b0, 1'b0);
        chk("preflush_count", 32'(count), 32'd3);
        cyc(1'b1, 32'h90, 1'b1, 1'b1);
        chk("flush_count", 32'(count), 32'h0);
        chk("flush_valid", 32'(out_valid), 32'h0);
        cyc(1'b1, 32'h100, 1'b0, 1'b0);
        chk("postflush_pc", out_pc, 32'h100);
        chk("postflush_count", 32'(count), 32'd1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush on empty queue just drops the input.
        cyc(1'b1, 32'h50, 1'b0, 1'b1);
        chk("empty_flush_count", 32'(count), 32'h0);
`ifdef FETCH_QUEUE_PERF_EN
        chk("stall_kept_by_flush", stall_cycles, 32'd3);
`endif

        // Asynchronous reset between edges with two entries queued.
        cyc(1'b1, 32'h300, 1'b0, 1'b0);
        cyc(1'b1, 32'h304, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_count", 32'(count), 32'h0);
        chk("async_in_ready", 32'(in_ready), 32'h1);
        chk("async_out_valid", 32'(out_valid), 32'h0);
        chk("async_out_pc", out_pc, 32'h0);
        chk("async_out_instr", out_instr, NOP);
`ifdef FETCH_QUEUE_PERF_EN
        chk("async_stall", stall_cycles, 32'h0);
`endif
        mcount = 0;
        exp_q.delete();
        #0 reset = 1'b1;
        cyc(1'b1, 32'h200, 1'b0, 1'b0);
        chk("post_rst_count", 32'(count), 32'd1);
        chk("post_rst_pc", out_pc, 32'h200);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("post_rst_empty", 32'(out_valid), 32'h0);

        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
